pipe_hazard_ctrl: RTL and testbench

//  Pipeline control unit for the 5-stage Y86-64 core. Sets the per-stage stall/bubble controls (F, D, E, M, W)

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage Y86-64 core: per-stage stall/bubble, post-reset flush, RUN/HALTED FSM, perf counters.
// Latency: stall/bubble/set_cc are combinational from the stage registers; halted/halt_stat/counters are registered (1 cycle).
// Backpressure: this block is the backpressure source; F_stall/D_stall/W_stall hold stages, bubbles inject nops.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   D_icode, d_srcA, d_srcB         decode-stage instruction and source registers (4'hf = none)
//   E_icode, E_dstM, e_Cnd          execute-stage instruction, load destination, jump condition
//   M_icode, m_stat, W_stat         memory-stage instruction/status, writeback status
//   F_stall..W_stall, set_cc        stage-register controls
//   halted, halt_stat               core stopped, and the status that stopped it
//   cyc_cnt, stall_cnt, mispred_cnt saturating RUN-only performance counters
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 5,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [3:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_POP   = 4'hb;
  localparam logic [3:0] R_NONE  = 4'hf;
  localparam logic [3:0] S_AOK   = 4'h1;
  localparam logic [3:0] S_HLT   = 4'h2;
  localparam logic [3:0] S_ADR   = 4'h3;
  localparam logic [3:0] S_INS   = 4'h4;

  // A zero-length flush is treated as a single flush cycle.
  localparam int FLUSH_LAST = (FLUSH_CYCLES <= 1) ? 0 : FLUSH_CYCLES - 1;
  localparam int FCW        = (FLUSH_LAST < 2) ? 1 : $clog2(FLUSH_LAST + 1);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [FCW-1:0] flush_cnt;

  logic lu;
  logic ret;
  logic mis;
  logic ex_m;
  logic ex_w;

  function automatic logic is_exc(input logic [3:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

  always_comb begin
    lu   = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != R_NONE) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mis  = (E_icode == I_JXX) && !e_Cnd;
    ex_m = is_exc(m_stat);
    ex_w = is_exc(W_stat);
  end

  always_comb begin
    state_d  = state_q;
    F_stall  = 1'b1;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    // The reset cycle drives flush controls whatever the stale state says.
    if (!reset) begin
      unique case (state_q)
        ST_FLUSH: begin
          if (flush_cnt == FCW'(FLUSH_LAST)) state_d = ST_RUN;
        end
        ST_RUN: begin
          F_stall  = lu | ret;
          D_stall  = lu;
          // A load/use stall holds D, so a ret in the pipe must not also bubble it.
          D_bubble = mis | (!lu & ret);
          E_bubble = mis | lu;
          M_bubble = ex_m | ex_w;
          W_stall  = ex_w;
          set_cc   = (E_icode == I_OPQ) & !ex_m & !ex_w;
          if (ex_w) state_d = ST_HALTED;
        end
        ST_HALTED: begin
          D_stall  = 1'b1;
          D_bubble = 1'b0;
          W_stall  = 1'b1;
        end
        default: state_d = ST_FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FLUSH;
      flush_cnt   <= '0;
      halted      <= 1'b0;
      halt_stat   <= S_AOK;
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FLUSH) flush_cnt <= flush_cnt + 1'b1;
      if (state_q == ST_RUN) begin
        if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
        if (lu && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (mis && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
        if (ex_w) begin
          halted    <= 1'b1;
          halt_stat <= W_stat;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model and literal spot checks.
// Two instances share stimulus: 32-bit counters and 4-bit counters for saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic e_Cnd;

  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [3:0]  halt_stat;
  logic [31:0] cyc_cnt, stall_cnt, mispred_cnt;

  logic F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc4, halted4;
  logic [3:0] halt_stat4, cyc_cnt4, stall_cnt4, mispred_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .halted(halted), .halt_stat(halt_stat), .cyc_cnt(cyc_cnt),
    .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall4), .D_stall(D_stall4),
    .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_stall(W_stall4),
    .set_cc(set_cc4), .halted(halted4), .halt_stat(halt_stat4), .cyc_cnt(cyc_cnt4),
    .stall_cnt(stall_cnt4), .mispred_cnt(mispred_cnt4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit      m_valid = 0;
  int      m_flush_left;
  bit      m_halted;
  int      m_hstat;
  longint  m_cyc, m_stall, m_mis;

  function automatic bit exc(input logic [3:0] s);
    return s == 4'd2 || s == 4'd3 || s == 4'd4;
  endfunction

  function automatic logic [31:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  always @(negedge clk) begin
    bit lu, rt, mis, exm, exw;
    bit eF, eDs, eDb, eE, eM, eW, eCC;
    lu  = (E_icode == 4'h5 || E_icode == 4'hb) && E_dstM != 4'hf &&
          (E_dstM == d_srcA || E_dstM == d_srcB);
    rt  = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    mis = E_icode == 4'h7 && !e_Cnd;
    exm = exc(m_stat);
    exw = exc(W_stat);
    if (reset || m_flush_left > 0) begin
      {eF, eDs, eDb, eE, eM, eW, eCC} = 7'b1011100;
    end else if (m_halted) begin
      {eF, eDs, eDb, eE, eM, eW, eCC} = 7'b1101110;
    end else begin
      eF  = lu || rt;
      eDs = lu;
      eDb = mis || (!lu && rt);
      eE  = mis || lu;
      eM  = exm || exw;
      eW  = exw;
      eCC = E_icode == 4'h6 && !exm && !exw;
    end
    if (m_valid) begin
      chk("F_stall", {31'd0, F_stall}, {31'd0, eF});
      chk("D_stall", {31'd0, D_stall}, {31'd0, eDs});
      chk("D_bubble", {31'd0, D_bubble}, {31'd0, eDb});
      chk("E_bubble", {31'd0, E_bubble}, {31'd0, eE});
      chk("M_bubble", {31'd0, M_bubble}, {31'd0, eM});
      chk("W_stall", {31'd0, W_stall}, {31'd0, eW});
      chk("set_cc", {31'd0, set_cc}, {31'd0, eCC});
      chk("D_stall_and_bubble", {31'd0, D_stall & D_bubble}, 32'd0);
      chk("halted", {31'd0, halted}, {31'd0, m_halted});
      chk("halt_stat", {28'd0, halt_stat}, 32'(m_hstat));
      chk("cyc_cnt", cyc_cnt, sat(m_cyc, 32));
      chk("stall_cnt", stall_cnt, sat(m_stall, 32));
      chk("mispred_cnt", mispred_cnt, sat(m_mis, 32));
      chk("cyc_cnt4", {28'd0, cyc_cnt4}, sat(m_cyc, 4));
      chk("stall_cnt4", {28'd0, stall_cnt4}, sat(m_stall, 4));
      chk("mispred_cnt4", {28'd0, mispred_cnt4}, sat(m_mis, 4));
    end
    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      m_valid = 1; m_flush_left = 5; m_halted = 0; m_hstat = 1;
      m_cyc = 0; m_stall = 0; m_mis = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (!m_halted) begin
      m_cyc++;
      if (lu) m_stall++;
      if (mis) m_mis++;
      if (exw) begin
        m_halted = 1;
        m_hstat  = int'(W_stat);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hf; d_srcB = 4'hf; E_dstM = 4'hf;
    e_Cnd = 1'b1; m_stat = 4'h1; W_stat = 4'h1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) step();
    reset = 1'b0;

    // Flush: five cycles of fetch stall and full bubbling, RUN on the sixth.
    for (int i = 0; i < 5; i++) begin
      chk("flush_F_stall", {31'd0, F_stall}, 32'd1);
      chk("flush_E_bubble", {31'd0, E_bubble}, 32'd1);
      chk("flush_M_bubble", {31'd0, M_bubble}, 32'd1);
      chk("flush_cyc_cnt", cyc_cnt, 32'd0);
      step();
    end
    chk("run_F_stall", {31'd0, F_stall}, 32'd0);
    chk("run_E_bubble", {31'd0, E_bubble}, 32'd0);
    step();
    chk("run_cyc_cnt", cyc_cnt, 32'd1);

    // Load/use.
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    chk("lu_F_stall", {31'd0, F_stall}, 32'd1);
    chk("lu_D_stall", {31'd0, D_stall}, 32'd1);
    chk("lu_E_bubble", {31'd0, E_bubble}, 32'd1);
    chk("lu_D_bubble", {31'd0, D_bubble}, 32'd0);
    step();
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    // Load/use together with ret in D.
    D_icode = 4'h9;
    #1;
    chk("luret_D_stall", {31'd0, D_stall}, 32'd1);
    chk("luret_D_bubble", {31'd0, D_bubble}, 32'd0);
    chk("luret_E_bubble", {31'd0, E_bubble}, 32'd1);
    step();
    idle();

    // ret walking through D, E, M.
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) D_icode = 4'h9;
      if (i == 1) E_icode = 4'h9;
      if (i == 2) M_icode = 4'h9;
      #1;
      chk("ret_F_stall", {31'd0, F_stall}, 32'd1);
      chk("ret_D_bubble", {31'd0, D_bubble}, 32'd1);
      chk("ret_D_stall", {31'd0, D_stall}, 32'd0);
      step();
    end
    idle();

    // Mispredicted jXX with ret in D behind it.
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9;
    #1;
    chk("mis_D_bubble", {31'd0, D_bubble}, 32'd1);
    chk("mis_E_bubble", {31'd0, E_bubble}, 32'd1);
    chk("mis_F_stall", {31'd0, F_stall}, 32'd1);
    step();
    idle();
    #1;
    chk("mis_cnt", mispred_cnt, 32'd1);

    // Long idle run drives the 4-bit counter into saturation.
    repeat (20) step();
    chk("sat_cyc_cnt4", {28'd0, cyc_cnt4}, 32'hf);

    // Exception in M, then in W, then halt.
    E_icode = 4'h6; m_stat = 4'h3;
    #1;
    chk("exm_M_bubble", {31'd0, M_bubble}, 32'd1);
    chk("exm_set_cc", {31'd0, set_cc}, 32'd0);
    step();
    idle();
    W_stat = 4'h3;
    #1;
    chk("exw_W_stall", {31'd0, W_stall}, 32'd1);
    chk("exw_halted_not_yet", {31'd0, halted}, 32'd0);
    step();
    idle();
    #1;
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_stat", {28'd0, halt_stat}, 32'd3);
    // Hazards while halted must not move counters.
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    repeat (3) step();
    chk("halt_stall_cnt", stall_cnt, 32'd2);
    chk("halt_mis_cnt", mispred_cnt, 32'd1);
    chk("halt_F_stall", {31'd0, F_stall}, 32'd1);
    chk("halt_D_bubble", {31'd0, D_bubble}, 32'd0);
    idle();

    // Reset from HALTED: flush controls during the reset cycle, everything cleared after.
    reset = 1'b1;
    #1;
    chk("rst_D_stall", {31'd0, D_stall}, 32'd0);
    chk("rst_D_bubble", {31'd0, D_bubble}, 32'd1);
    step();
    reset = 1'b0;
    #1;
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cyc_cnt", cyc_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_halt_stat", {28'd0, halt_stat}, 32'd1);
    repeat (5) step();
    chk("rerun_F_stall", {31'd0, F_stall}, 32'd0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
